// File: rtl/gba_bw_bank_streamer.sv
// gba_bw_bank_streamer
// Walks one 1-bit-per-pixel image bank from address 0 to DEPTH-1. Each byte
// is expanded MSB first into RGB565 pixels, and each pixel is sent as two
// bytes (high byte first) on a valid/ready byte stream.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start              begin a bank run (honoured only when idle)
//   busy, done         run in progress / one-cycle end-of-run pulse
//   rd_en, rd_addr     one-cycle read strobe and address to the bank
//   rd_data, rd_valid  bank read return; data taken only while waiting
//   tx_data, tx_valid  pixel byte stream to the SPI byte engine
//   tx_ready           SPI engine accepts the byte
//   dbg_state          current FSM state (IDLE=0 FETCH=1 WAIT=2 EMIT=3 DONE=4)
//
// Handshake: a byte transfers on a rising edge where tx_valid and tx_ready
// are both high. Once tx_valid rises, it and tx_data hold until that
// transfer; tx_valid never depends on tx_ready.
module gba_bw_bank_streamer #(
  parameter int          DEPTH    = 512,
  parameter int          ADDR_W   = 9,
  parameter logic [15:0] FG_COLOR = 16'h0000,
  parameter logic [15:0] BG_COLOR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              rd_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [7:0]        shreg_q, shreg_n;
  logic [2:0]        bit_q, bit_n;
  logic              half_q, half_n;
  logic              hs;
  logic [15:0]       color_n;
  logic [7:0]        byte_n;

  // tx_valid is only ever high in EMIT, so this is the EMIT handshake.
  assign hs = tx_valid & tx_ready;

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    shreg_n = shreg_q;
    bit_n   = bit_q;
    half_n  = half_q;
    case (state_q)
      S_IDLE: begin
        addr_n = '0;
        if (start) state_n = S_FETCH;
      end
      S_FETCH: state_n = S_WAIT;
      S_WAIT: begin
        if (rd_valid) begin
          shreg_n = rd_data;
          bit_n   = 3'd0;
          half_n  = 1'b0;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (hs) begin
          if (!half_q) begin
            half_n = 1'b1;
          end else begin
            half_n  = 1'b0;
            shreg_n = {shreg_q[6:0], 1'b0};
            bit_n   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (addr_q == LAST_ADDR) begin
                state_n = S_DONE;
              end else begin
                addr_n  = addr_q + 1'b1;
                state_n = S_FETCH;
              end
            end
          end
        end
      end
      S_DONE: begin
        addr_n  = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe without any combinational path to the ports.
  assign color_n = shreg_n[7] ? BG_COLOR : FG_COLOR;
  assign byte_n  = half_n ? color_n[7:0] : color_n[15:8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      shreg_q  <= 8'h00;
      bit_q    <= 3'd0;
      half_q   <= 1'b0;
      rd_en    <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      addr_q   <= addr_n;
      shreg_q  <= shreg_n;
      bit_q    <= bit_n;
      half_q   <= half_n;
      rd_en    <= (state_n == S_FETCH);
      tx_valid <= (state_n == S_EMIT);
      tx_data  <= (state_n == S_EMIT) ? byte_n : 8'h00;
      busy     <= (state_n == S_FETCH) || (state_n == S_WAIT) || (state_n == S_EMIT);
      done     <= (state_n == S_DONE);
    end
  end

  assign rd_addr   = addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gba_bw_bank_streamer.sv
// Bench for gba_bw_bank_streamer: a behavioural bank model with adjustable
// read latency, a stream monitor, and scenario tasks comparing the captured
// byte stream against an expected queue built from the bank contents.
module tb_gba_bw_bank_streamer;

  localparam int DEPTH = 512;
  localparam int ADDR_W = 9;
  localparam logic [15:0] FG = 16'h0000;
  localparam logic [15:0] BG = 16'hFFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              busy, done, rd_en, tx_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b0;
  logic [2:0]        dbg_state;

  gba_bw_bank_streamer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- bank model ----------------
  logic [7:0]        mem [0:DEPTH-1];
  int                bank_lat = 1;
  bit                spur_en = 1'b0;
  int                spur_cnt = 0;
  int                pc;
  logic [ADDR_W-1:0] pa;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      pc       <= 0;
      pa       <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_en) begin
        pa <= rd_addr;
        if (bank_lat <= 1) begin
          pc       <= 0;
          rd_valid <= 1'b1;
          rd_data  <= mem[rd_addr];
        end else begin
          pc <= bank_lat - 1;
        end
      end else if (pc > 1) begin
        pc <= pc - 1;
      end else if (pc == 1) begin
        pc       <= 0;
        rd_valid <= 1'b1;
        rd_data  <= mem[pa];
      end else if (spur_en && tx_valid && ($urandom_range(0, 3) == 0)) begin
        rd_valid <= 1'b1;
        rd_data  <= 8'h00;
        spur_cnt <= spur_cnt + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int  cyc = 0;
  int  first_valid_cyc = -1;
  int  done_cyc = -1;
  int  done_cnt = 0;
  int  stab_err = 0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (resetn) begin
      cyc = cyc + 1;
      if (tx_valid && tx_ready) obs_q.push_back(tx_data);
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (rd_en) addr_q.push_back(rd_addr);
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err = stab_err + 1;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;

  // ---------------- model / drivers ----------------
  task automatic build_exp();
    logic [15:0] c;
    exp_q = {};
    for (int a = 0; a < DEPTH; a++) begin
      for (int b = 7; b >= 0; b--) begin
        c = mem[a][b] ? BG : FG;
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
      end
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
  endtask

  task automatic fill_image();
    for (int a = 0; a < DEPTH; a++) mem[a] = (a < 484) ? 8'hFF : 8'h00;
    mem[484] = 8'b1110_0000;
  endtask

  task automatic clear_mon();
    obs_q = {};
    addr_q = {};
    first_valid_cyc = -1;
    done_cyc = -1;
    done_cnt = 0;
    stab_err = 0;
    cyc = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Starts a run and drives tx_ready until done, a handshake budget, or timeout.
  task automatic run_bank(input int duty, input int max_cycles, input int stop_hs,
                          input int pulse_addr, output bit timed_out);
    int  n;
    bit  pulsed;
    clear_mon();
    timed_out = 1'b0;
    pulsed = 1'b0;
    start = 1'b1;
    tx_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < max_cycles) begin
      if (stop_hs > 0 && obs_q.size() >= stop_hs) break;
      tx_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      if (pulse_addr >= 0 && !pulsed && busy && rd_addr == pulse_addr[ADDR_W-1:0]) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (n >= max_cycles) timed_out = 1'b1;
    if (stop_hs == 0) repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit to;
    int mism;
    do_reset();
    checks++;
    if ({busy, done, rd_en, tx_valid} !== 4'b0000 || rd_addr !== '0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_vals: busy=%b done=%b rd_en=%b tx_valid=%b rd_addr=%0d tx_data=%h, required all 0",
               busy, done, rd_en, tx_valid, rd_addr, tx_data);
    end
    fill_random();
    build_exp();
    run_bank(100, 2000, 40, -1, to);
    checks++;
    if (to || !tx_valid) begin
      failures++;
      $display("FAIL reset_reach_emit: timeout=%b tx_valid=%b, required EMIT reached", to, tx_valid);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || rd_addr !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_emit: tx_valid=%b rd_en=%b busy=%b rd_addr=%0d done=%b, required 0",
               tx_valid, rd_en, busy, rd_addr, done);
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    run_bank(100, 2000, 32, -1, to);
    mism = 0;
    for (int i = 0; i < 32; i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0 || addr_q.size() < 2 || addr_q[0] !== '0 || addr_q[1] !== 9'd1) begin
      failures++;
      $display("FAIL reset_restart: byte_mismatches=%0d fetches=%0d first_addr=%0d, required 0 mismatches from addr 0",
               mism, addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 9'h1FF);
    end
    do_reset();
  endtask

  task automatic test_full_bank();
    bit to;
    int mism;
    int span;
    fill_image();
    build_exp();
    bank_lat = 1;
    run_bank(100, 12000, 0, -1, to);
    checks++;
    if (to || obs_q.size() != DEPTH * 16) begin
      failures++;
      $display("FAIL full_count: handshakes=%0d timeout=%b, required %0d", obs_q.size(), to, DEPTH * 16);
    end
    if (obs_q.size() == DEPTH * 16) begin
      mism = 0;
      for (int i = 0; i < 484 * 16; i++) if (obs_q[i] !== 8'hFF) mism++;
      checks++;
      if (mism != 0) begin
        failures++;
        $display("FAIL full_ff_region: non_ff_bytes=%0d, required 0", mism);
      end
      mism = 0;
      for (int i = 0; i < 16; i++) if (obs_q[484 * 16 + i] !== ((i < 6) ? 8'hFF : 8'h00)) mism++;
      checks++;
      if (mism != 0) begin
        failures++;
        $display("FAIL full_addr484: mismatched_bytes=%0d, required 6xFF then 10x00", mism);
      end
      mism = 0;
      for (int i = 0; i < 16; i++) if (obs_q[504 * 16 + i] !== 8'h00) mism++;
      checks++;
      if (mism != 0) begin
        failures++;
        $display("FAIL full_addr504: non_zero_bytes=%0d, required 0", mism);
      end
      mism = 0;
      for (int i = 0; i < DEPTH * 16; i++) if (obs_q[i] !== exp_q[i]) mism++;
      checks++;
      if (mism != 0) begin
        failures++;
        $display("FAIL full_seq: mismatched_bytes=%0d, required 0", mism);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL full_done_count: got=%0d required=1", done_cnt);
    end
    span = done_cyc - first_valid_cyc;
    checks++;
    if (span < DEPTH * 18 - 2 || span > DEPTH * 18 + 2) begin
      failures++;
      $display("FAIL full_done_time: got=%0d required=%0d+-2", span, DEPTH * 18);
    end
    mism = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== ADDR_W'(i)) mism++;
    checks++;
    if (addr_q.size() != DEPTH || mism != 0) begin
      failures++;
      $display("FAIL full_addr_seq: fetches=%0d bad=%0d, required %0d in order", addr_q.size(), mism, DEPTH);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int mism;
    fill_random();
    build_exp();
    bank_lat = 1;
    run_bank(30, 40000, 0, -1, to);
    mism = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || obs_q.size() != exp_q.size() || mism != 0) begin
      failures++;
      $display("FAIL bp_seq: bytes=%0d mismatches=%0d timeout=%b, required %0d bytes 0 mismatches",
               obs_q.size(), mism, to, exp_q.size());
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL bp_stable: violations=%0d required=0", stab_err);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL bp_done_count: got=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_bank_latency();
    bit to;
    int mism;
    fill_random();
    build_exp();
    bank_lat = 3;
    run_bank(100, 14000, 0, -1, to);
    bank_lat = 1;
    mism = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== ADDR_W'(i)) mism++;
    checks++;
    if (addr_q.size() != DEPTH || mism != 0) begin
      failures++;
      $display("FAIL lat3_addr_seq: fetches=%0d bad=%0d, required %0d in order", addr_q.size(), mism, DEPTH);
    end
    mism = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || obs_q.size() != exp_q.size() || mism != 0) begin
      failures++;
      $display("FAIL lat3_seq: bytes=%0d mismatches=%0d timeout=%b, required %0d bytes",
               obs_q.size(), mism, to, exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    int mism;
    fill_random();
    build_exp();
    run_bank(100, 12000, 0, 100, to);
    checks++;
    if (done_cnt != 1 || to) begin
      failures++;
      $display("FAIL start_busy_done: done_count=%0d timeout=%b, required 1", done_cnt, to);
    end
    mism = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== ADDR_W'(i)) mism++;
    checks++;
    if (addr_q.size() != DEPTH || mism != 0) begin
      failures++;
      $display("FAIL start_busy_addr: fetches=%0d bad=%0d, required %0d in order", addr_q.size(), mism, DEPTH);
    end
  endtask

  task automatic test_spurious_valid();
    bit to;
    int mism;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom) | 8'h81;
    build_exp();
    spur_en = 1'b1;
    run_bank(100, 12000, 0, -1, to);
    spur_en = 1'b0;
    mism = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || obs_q.size() != exp_q.size() || mism != 0) begin
      failures++;
      $display("FAIL spurious_seq: bytes=%0d mismatches=%0d injected=%0d, required %0d bytes 0 mismatches",
               obs_q.size(), mism, spur_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_bank();
    test_backpressure();
    test_bank_latency();
    test_start_while_busy();
    test_spurious_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gba_bw_bank_streamer.md
# gba_bw_bank_streamer

Reads every byte of one 1-bit-per-pixel intro-image block RAM bank in address order. Expands each bit, MSB first, into an RGB565 pixel and sends it as two bytes, high byte first, over a valid/ready byte stream. The stream feeds the SPI LCD byte transmitter. The block sits between the image bank (rd_en/rd_addr/data_out/valid_out) and the SPI byte engine, and is started once per bank by the frame sequencer.

## Interface
- DEPTH, 512, number of bytes in the bank
- ADDR_W, 9, bank address width
- FG_COLOR, 16'h0000, RGB565 colour for a bit value of 0
- BG_COLOR, 16'hFFFF, RGB565 colour for a bit value of 1
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin streaming the bank; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse when the last byte has been handshaken
- rd_en  out  1  read strobe to the bank, exactly one cycle per fetch
- rd_addr  out  ADDR_W  bank address
- rd_data  in  8  bank data_out
- rd_valid  in  1  bank valid_out; rd_data is captured only when this is high
- tx_data  out  8  pixel byte to the SPI engine
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  SPI engine accepts; a handshake occurs when tx_valid and tx_ready are both high

## Operation
- States: IDLE, FETCH, WAIT, EMIT, DONE.
- IDLE:
  - start=1 → FETCH.
  - Address counter cleared to 0.
- FETCH:
  - rd_en=1 for one cycle with rd_addr = address counter.
  - Next state is WAIT.
- WAIT:
  - rd_en=0.
  - Waits an unbounded number of cycles for rd_valid=1.
  - On rd_valid, latches rd_data into the shift register, clears bit/half counters, goes to EMIT.
- EMIT:
  - Current bit is the shift register MSB. Colour is BG_COLOR if the bit is 1, else FG_COLOR.
  - tx_data shows colour[15:8] first, then colour[7:0].
  - The half counter advances only on a handshake. After the low byte is handshaken, the shift register shifts left by 1 and the bit counter increments.
  - After the 16th handshake for the byte:
    - If the address is DEPTH-1 → DONE.
    - Otherwise the address increments and the state goes to FETCH.
- DONE:
  - done=1 for one cycle, busy falls, state returns to IDLE.
- start is ignored in every state except IDLE.
- rd_valid outside WAIT is ignored.
- Totals per run: DEPTH×8 pixels and DEPTH×16 tx bytes (8192 for the default).
- rd_addr never exceeds DEPTH-1. There is no wrap; the run ends at DEPTH-1.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, tx_valid=0, tx_data=8'h00, state IDLE.
- All outputs are registered.
- Start to first byte:
  - start sampled at edge E0.
  - rd_en=1 during the cycle after E0.
  - With a 1-cycle bank, rd_valid arrives one cycle later and is latched at that edge.
  - tx_valid=1 from the following cycle, 3 cycles after E0.
- tx_valid stays high and tx_data stays stable until the handshake.
- With tx_ready tied high, each byte takes 16 cycles and there are 2 dead cycles (FETCH, WAIT) between bank bytes: DEPTH×18 cycles per bank.
- done is asserted the cycle after the final handshake. tx_valid is 0 in that cycle.
- Reset mid-operation: all state is returned to reset values immediately and asynchronously. A pending tx byte is dropped. The next start restarts at address 0.

## Test plan
- Reset: assert resetn=0 mid-EMIT → next cycle tx_valid=0, rd_en=0, busy=0, rd_addr=0. After release, start streams from address 0.
- Full bank, tx_ready=1, real bank contents:
  - Exactly 8192 handshakes.
  - Addresses 0–483 each produce 16×8'hFF.
  - Address 484 (8'b11100000) → 6×8'hFF then 10×8'h00.
  - Address 504 (8'h00) → 16×8'h00.
  - done exactly once, 9216 cycles after tx_valid first rises, ±2.
- Backpressure: tx_ready driven with a random 30% duty → tx_data stable while tx_valid=1 and tx_ready=0. The byte sequence is identical to the tx_ready=1 run.
- Bank latency 3 cycles (rd_valid delayed) → one rd_en per address, no duplicate or skipped addresses, same byte sequence.
- start pulsed while busy at address 100 → ignored. A single done; rd_addr sequence unaffected.
- Spurious rd_valid during EMIT with rd_data=8'h00 → ignored. The output for the current byte is unchanged.
